// File: rtl/mesm6_io_pkg.sv
// Shared types and field positions for the MESM-6 peripheral I/O initiator.
package mesm6_io_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} io_state_t;

    localparam int unsigned IO_SLOT_LSB = 3;
    localparam int unsigned IO_SLOT_MSB = 5;
    localparam int unsigned IO_SLOT_W   = IO_SLOT_MSB - IO_SLOT_LSB + 1;
    localparam int unsigned IO_REG_W    = 3;
    localparam int unsigned IO_ADDR_W   = 15;
    localparam int unsigned IO_DATA_W   = 48;

    function automatic logic [IO_SLOT_W-1:0] io_slot(input logic [IO_ADDR_W-1:0] addr);
        return addr[IO_SLOT_MSB:IO_SLOT_LSB];
    endfunction

endpackage

// File: rtl/mesm6_io_master_if.sv
// CPU-side request/response and per-slot peripheral bus of the MESM-6 I/O initiator.
interface mesm6_io_master_if
    import mesm6_io_pkg::*;
#(
    parameter int unsigned NDEV = 4
) ();

    logic [IO_ADDR_W-1:0]      io_addr;
    logic                      io_read;
    logic                      io_write;
    logic [IO_DATA_W-1:0]      io_wdata;
    logic [IO_DATA_W-1:0]      io_rdata;
    logic                      io_done;
    logic                      io_error;
    logic [IO_ADDR_W-1:0]      dev_addr;
    logic [IO_DATA_W-1:0]      dev_wdata;
    logic [NDEV-1:0]           dev_read;
    logic [NDEV-1:0]           dev_write;
    logic [IO_DATA_W*NDEV-1:0] dev_rdata;
    logic [NDEV-1:0]           dev_done;

    modport master (
        input  io_addr, io_read, io_write, io_wdata, dev_rdata, dev_done,
        output io_rdata, io_done, io_error, dev_addr, dev_wdata, dev_read, dev_write
    );

    modport slave (
        output io_addr, io_read, io_write, io_wdata, dev_rdata, dev_done,
        input  io_rdata, io_done, io_error, dev_addr, dev_wdata, dev_read, dev_write
    );

endinterface

// File: rtl/mesm6_io_master.sv
// MESM-6 peripheral I/O bus initiator: decodes a CPU request to one of NDEV slots.
// Define MESM6_IO_TIMEOUT_EN to enable the dev_done timeout (TIMEOUT cycles).
module mesm6_io_master
    import mesm6_io_pkg::*;
#(
    parameter int unsigned NDEV    = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    mesm6_io_master_if.master bus
);

    if (NDEV < 1 || NDEV > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("mesm6_io_master: NDEV or TIMEOUT out of range");
    end

    io_state_t             state_q, state_d;
    logic [IO_ADDR_W-1:0]  dev_addr_q, dev_addr_d;
    logic [IO_DATA_W-1:0]  dev_wdata_q, dev_wdata_d;
    logic [NDEV-1:0]       dev_read_q, dev_read_d;
    logic [NDEV-1:0]       dev_write_q, dev_write_d;
    logic                  io_done_q, io_done_d;
    logic                  io_error_q, io_error_d;
    logic [IO_DATA_W-1:0]  io_rdata_q, io_rdata_d;
`ifdef MESM6_IO_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);
    logic [15:0]           timer_q, timer_d;
`endif

    logic [IO_SLOT_W-1:0]  req_slot;
    logic                  req_slot_ok;
    logic [NDEV-1:0]       req_onehot;
    logic                  acc_done;
    logic [IO_DATA_W-1:0]  acc_rdata;

    // The held strobe vector is the latched slot select; write strobes never return data.
    always_comb begin
        req_slot    = io_slot(bus.io_addr);
        req_slot_ok = 32'(req_slot) < NDEV;
        acc_done    = |(bus.dev_done & (dev_read_q | dev_write_q));
        acc_rdata   = '0;
        for (int k = 0; k < NDEV; k++) begin
            req_onehot[k] = (req_slot == IO_SLOT_W'(k));
            if (dev_read_q[k]) acc_rdata = bus.dev_rdata[k*IO_DATA_W +: IO_DATA_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        dev_addr_d  = dev_addr_q;
        dev_wdata_d = dev_wdata_q;
        dev_read_d  = dev_read_q;
        dev_write_d = dev_write_q;
        io_done_d   = 1'b0;
        io_error_d  = io_error_q;
        io_rdata_d  = io_rdata_q;
`ifdef MESM6_IO_TIMEOUT_EN
        timer_d     = timer_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.io_read || bus.io_write) begin
                    dev_addr_d  = bus.io_addr;
                    dev_wdata_d = bus.io_wdata;
`ifdef MESM6_IO_TIMEOUT_EN
                    timer_d     = '0;
`endif
                    if ((bus.io_read && bus.io_write) || !req_slot_ok) begin
                        state_d    = RESP;
                        io_done_d  = 1'b1;
                        io_error_d = 1'b1;
                        io_rdata_d = '0;
                    end else begin
                        state_d     = ACCESS;
                        dev_read_d  = bus.io_read  ? req_onehot : '0;
                        dev_write_d = bus.io_write ? req_onehot : '0;
                    end
                end
            end
            ACCESS: begin
                if (acc_done) begin
                    state_d     = RESP;
                    io_done_d   = 1'b1;
                    io_error_d  = 1'b0;
                    io_rdata_d  = acc_rdata;
                    dev_read_d  = '0;
                    dev_write_d = '0;
                end
`ifdef MESM6_IO_TIMEOUT_EN
                else if (timer_q == TimeoutLast) begin
                    state_d     = RESP;
                    io_done_d   = 1'b1;
                    io_error_d  = 1'b1;
                    io_rdata_d  = '0;
                    dev_read_d  = '0;
                    dev_write_d = '0;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
`endif
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            dev_addr_q  <= '0;
            dev_wdata_q <= '0;
            dev_read_q  <= '0;
            dev_write_q <= '0;
            io_done_q   <= 1'b0;
            io_error_q  <= 1'b0;
            io_rdata_q  <= '0;
`ifdef MESM6_IO_TIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            dev_addr_q  <= dev_addr_d;
            dev_wdata_q <= dev_wdata_d;
            dev_read_q  <= dev_read_d;
            dev_write_q <= dev_write_d;
            io_done_q   <= io_done_d;
            io_error_q  <= io_error_d;
            io_rdata_q  <= io_rdata_d;
`ifdef MESM6_IO_TIMEOUT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    assign bus.io_rdata  = io_rdata_q;
    assign bus.io_done   = io_done_q;
    assign bus.io_error  = io_error_q;
    assign bus.dev_addr  = dev_addr_q;
    assign bus.dev_wdata = dev_wdata_q;
    assign bus.dev_read  = dev_read_q;
    assign bus.dev_write = dev_write_q;

endmodule

// File: tb/tb_mesm6_io_master.sv
// Bench for mesm6_io_master: directed and random accesses against a transaction-level model.
module tb_mesm6_io_master;
    import mesm6_io_pkg::*;

    localparam int unsigned NDEV    = 4;
    localparam int unsigned TIMEOUT = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mesm6_io_master_if #(.NDEV(NDEV)) bus ();

    mesm6_io_master #(.NDEV(NDEV), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;

    // Responder register files, and the model's view of what they should hold.
    logic [47:0] dev_mem [NDEV][8];
    logic [47:0] shadow  [8][8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request: cycle 0 drives it; the model predicts the completion cycle, strobes and result.
    task automatic do_txn(input logic [14:0] addr, input logic rd, input logic wr,
                          input logic [47:0] wdata, input int lat);
        int slot;
        int off;
        bit err;
        bit tmo;
        int d;
        logic [47:0] exp_rd;
        logic [NDEV-1:0] exp_strobe;
        logic [NDEV-1:0] exp_r;
        logic [NDEV-1:0] exp_w;
        slot = int'(addr[5:3]);
        off  = int'(addr[2:0]);
        err  = (rd && wr) || (slot >= NDEV);
`ifdef MESM6_IO_TIMEOUT_EN
        tmo  = !err && (lat >= TIMEOUT);
`else
        tmo  = 1'b0;
`endif
        d = err ? 1 : (tmo ? TIMEOUT + 1 : lat + 2);
        exp_rd = (!err && !tmo && rd) ? shadow[slot][off] : 48'd0;
        exp_strobe = err ? '0 : (NDEV'(1) << slot);
        if (!err && !tmo && wr) shadow[slot][off] = wdata;

        @(negedge clk);
        bus.io_addr  = addr;
        bus.io_read  = rd;
        bus.io_write = wr;
        bus.io_wdata = wdata;
        for (int c = 1; c <= d + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.io_read  = 1'b0;
                bus.io_write = 1'b0;
                bus.io_addr  = 15'($urandom);
                bus.io_wdata = 48'({$urandom(), $urandom()});
            end
            exp_r = (c < d && rd) ? exp_strobe : '0;
            exp_w = (c < d && wr) ? exp_strobe : '0;
            check("dev_read", 64'(bus.dev_read), 64'(exp_r));
            check("dev_write", 64'(bus.dev_write), 64'(exp_w));
            check("io_done", 64'(bus.io_done), 64'(c == d));
            if (c < d && !err) begin
                check("dev_addr", 64'(bus.dev_addr), 64'(addr));
                if (wr) check("dev_wdata", 64'(bus.dev_wdata), 64'(wdata));
            end
            if (c == d) begin
                check("io_error", 64'(bus.io_error), 64'(err || tmo));
                check("io_rdata", 64'(bus.io_rdata), 64'(exp_rd));
            end
            bus.dev_done  = NDEV'($urandom) & ~exp_strobe;
            bus.dev_rdata = (NDEV*48)'({$urandom(), $urandom(), $urandom(), $urandom(),
                                        $urandom(), $urandom()});
            if (!err && c == lat + 1 && c < d) begin
                bus.dev_done = bus.dev_done | exp_strobe;
                if (bus.dev_write[slot]) dev_mem[slot][bus.dev_addr[2:0]] = bus.dev_wdata;
                bus.dev_rdata[slot*48 +: 48] = dev_mem[slot][bus.dev_addr[2:0]];
            end
        end
        bus.dev_done = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int slot;
        int op;
        bus.io_addr   = '0;
        bus.io_read   = 1'b0;
        bus.io_write  = 1'b0;
        bus.io_wdata  = '0;
        bus.dev_rdata = '0;
        bus.dev_done  = '0;
        for (int s = 0; s < 8; s++) begin
            for (int o = 0; o < 8; o++) begin
                shadow[s][o] = 48'((s * 8 + o) * 32'h0001_0203);
                if (s < NDEV) dev_mem[s][o] = 48'((s * 8 + o) * 32'h0001_0203);
            end
        end

        repeat (2) @(negedge clk);
        check("rst_io_done", 64'(bus.io_done), 64'd0);
        check("rst_io_error", 64'(bus.io_error), 64'd0);
        check("rst_io_rdata", 64'(bus.io_rdata), 64'd0);
        check("rst_dev_read", 64'(bus.dev_read), 64'd0);
        check("rst_dev_write", 64'(bus.dev_write), 64'd0);
        check("rst_dev_addr", 64'(bus.dev_addr), 64'd0);
        check("rst_dev_wdata", 64'(bus.dev_wdata), 64'd0);
        reset_n = 1'b1;

        dev_mem[1][6] = 48'o1234;
        shadow[1][6]  = 48'o1234;
        do_txn(15'o16, 1'b1, 1'b0, 48'd0, 1);
        do_txn(15'o06, 1'b0, 1'b1, 48'hA5A5_0000_FFFF, 1);
        do_txn(15'o06, 1'b1, 1'b0, 48'd0, 0);
        do_txn(15'o50, 1'b1, 1'b0, 48'd0, 1);
        do_txn(15'o16, 1'b1, 1'b1, 48'h1234_5678_9ABC, 1);
        do_txn(15'o20, 1'b1, 1'b0, 48'd0, 120);

        // Reset in the second ACCESS cycle of a read that never completes.
        @(negedge clk);
        bus.io_addr = 15'o30;
        bus.io_read = 1'b1;
        @(negedge clk);
        bus.io_read = 1'b0;
        check("abort_strobe1", 64'(bus.dev_read), 64'(4'b1000));
        @(negedge clk);
        check("abort_strobe2", 64'(bus.dev_read), 64'(4'b1000));
        reset_n = 1'b0;
        #1;
        check("abort_read_clr", 64'(bus.dev_read), 64'd0);
        check("abort_write_clr", 64'(bus.dev_write), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", 64'(bus.io_done), 64'd0);
        end
        reset_n = 1'b1;
        do_txn(15'o31, 1'b1, 1'b0, 48'd0, 1);

        for (int n = 0; n < 40; n++) begin
            slot = $urandom_range(0, 5);
            op   = $urandom_range(0, 9);
            do_txn({9'($urandom), 3'(slot), 3'($urandom_range(0, 7))},
                   op == 0 || op >= 5, op <= 4,
                   48'({$urandom(), $urandom()}), $urandom_range(0, 11));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
